// File: rtl/serial_err_sched_pkg.sv
// Shared definitions for the serial error-injection path: error-mode
// encodings, sequencer FSM states and default widths. Used by the frame
// sequencer, the error injector and the checker.
package serial_err_sched_pkg;

  localparam int unsigned DEF_WORD_W = 7;
  localparam int unsigned DEF_POS_W  = 3;

  // err_mode encodings as seen on the err_mode port
  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,  // error_pos = 0
    ERR_FIXED  = 2'd1,  // error_pos = err_fixed
    ERR_SWEEP1 = 2'd2,  // sweep 1..max, skipping 0
    ERR_SWEEP0 = 2'd3   // sweep 0..max
  } err_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/serial_err_sched_err_pos_gen.sv
// err_pos_gen: per-frame error position scheduler.
//   clk, rst   : clock, synchronous active-high reset
//   accept     : a word is being accepted this cycle; schedule advances
//   mode       : error mode sampled at acceptance
//   fixed      : fixed position sampled at acceptance (ERR_FIXED)
//   error_pos  : registered position, held until the next acceptance
module err_pos_gen
  import serial_err_sched_pkg::*;
#(
  parameter int unsigned POS_W = DEF_POS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  err_mode_e        mode,
  input  logic [POS_W-1:0] fixed,
  output logic [POS_W-1:0] error_pos
);

  logic [POS_W-1:0] sweep_ptr_q, sweep_ptr_d;
  logic [POS_W-1:0] error_pos_q, error_pos_d;
  logic [POS_W-1:0] p;

  always_comb begin
    sweep_ptr_d = sweep_ptr_q;
    error_pos_d = error_pos_q;
    p           = sweep_ptr_q;
    if (accept) begin
      unique case (mode)
        ERR_NONE:  error_pos_d = '0;
        ERR_FIXED: error_pos_d = fixed;
        ERR_SWEEP1: begin
          // a pointer left at 0 by the 0..max sweep is promoted to 1
          p           = (sweep_ptr_q == '0) ? POS_W'(1) : sweep_ptr_q;
          error_pos_d = p;
          sweep_ptr_d = (p == '1) ? POS_W'(1) : p + POS_W'(1);
        end
        ERR_SWEEP0: begin
          error_pos_d = sweep_ptr_q;
          sweep_ptr_d = sweep_ptr_q + POS_W'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_ptr_q <= '0;
      error_pos_q <= '0;
    end else begin
      sweep_ptr_q <= sweep_ptr_d;
      error_pos_q <= error_pos_d;
    end
  end

  assign error_pos = error_pos_q;

endmodule

// File: rtl/serial_err_sched.sv
// serial_err_sched: frame sequencer for the serial error-injection path.
// Accepts codewords on a valid/ready handshake, serialises them LSB-first
// as a d/strobe pair (two cycles per bit, strobe on the second), then idles
// GAP_CYC cycles. error_pos follows a per-frame schedule fixed at acceptance.
//   word_in/word_valid/word_ready : codeword handshake
//   err_mode/err_fixed            : schedule selection, sampled at acceptance
//   d_ser/strobe_ser              : serial data and bit strobe to the injector
//   error_pos                     : injector error position for this frame
//   busy                          : frame in flight (SHIFT or GAP)
//   frame_done                    : one-cycle pulse on the first GAP cycle
//   frame_cnt                     : completed frames, wrapping
module serial_err_sched
  import serial_err_sched_pkg::*;
#(
  parameter int unsigned WORD_W  = DEF_WORD_W,
  parameter int unsigned POS_W   = DEF_POS_W,
  parameter int unsigned GAP_CYC = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [1:0]        err_mode,
  input  logic [POS_W-1:0]  err_fixed,
  output logic              d_ser,
  output logic              strobe_ser,
  output logic [POS_W-1:0]  error_pos,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYC - 1);

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               phase_q, phase_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;

  assign accept = (state_q == ST_IDLE) && word_valid;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
          shreg_d = word_in;
          bit_d   = '0;
          phase_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          // current bit always sits in shreg_q[0]; shift after its strobe
          phase_d = 1'b0;
          shreg_d = shreg_q >> 1;
          if (bit_q == LAST_BIT) begin
            state_d = ST_GAP;
            gap_d   = '0;
            done_d  = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (gap_q == LAST_GAP) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      gap_q   <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  err_pos_gen #(
    .POS_W (POS_W)
  ) u_err_pos_gen (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .mode      (err_mode_e'(err_mode)),
    .fixed     (err_fixed),
    .error_pos (error_pos)
  );

  assign word_ready = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign d_ser      = (state_q == ST_SHIFT) && shreg_q[0];
  assign strobe_ser = (state_q == ST_SHIFT) && phase_q;
  assign frame_done = done_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_serial_err_sched.sv
module tb_serial_err_sched;

  localparam int WORD_W  = 7;
  localparam int POS_W   = 3;
  localparam int GAP_CYC = 1;
  localparam int CNT_W   = 8;
  localparam int FRAME   = 2 * WORD_W + GAP_CYC + 1;
  localparam int MAXP    = (1 << POS_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [WORD_W-1:0] word_in = '0;
  logic              word_valid = 1'b0;
  logic              word_ready;
  logic [1:0]        err_mode = 2'd0;
  logic [POS_W-1:0]  err_fixed = '0;
  logic              d_ser;
  logic              strobe_ser;
  logic [POS_W-1:0]  error_pos;
  logic              busy;
  logic              frame_done;
  logic [CNT_W-1:0]  frame_cnt;

  serial_err_sched #(
    .WORD_W  (WORD_W),
    .POS_W   (POS_W),
    .GAP_CYC (GAP_CYC),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .err_mode   (err_mode),
    .err_fixed  (err_fixed),
    .d_ser      (d_ser),
    .strobe_ser (strobe_ser),
    .error_pos  (error_pos),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 20)
        $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WORD_W-1:0] pos_mask(input logic [POS_W-1:0] p);
    if (p == '0) return '0;
    return WORD_W'(1) << (p - 1);
  endfunction

  // ---------------- reference model (updated on each rising edge) -------------
  typedef struct {
    logic [WORD_W-1:0] word;
    logic [POS_W-1:0]  pos;
  } exp_t;

  exp_t              exp_q[$];
  int                pos_log[$];
  bit                m_active = 0;
  int                m_k = 0;        // cycle offset inside the frame, 1 = first SHIFT cycle
  logic [WORD_W-1:0] m_word = '0;
  logic [POS_W-1:0]  m_pos = '0;
  int                m_ptr = 0;
  logic [CNT_W-1:0]  m_cnt = '0;
  int                p;

  int                rx_n = 0;
  logic [WORD_W-1:0] rx_word = '0;
  logic [WORD_W-1:0] inj_word = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_k = 0; m_pos = '0; m_ptr = 0; m_cnt = '0;
      exp_q.delete();
      rx_n = 0; rx_word = '0; inj_word = '0;
    end else if ((!m_active || m_k >= FRAME) && word_valid) begin
      m_active = 1;
      m_k      = 1;
      m_word   = word_in;
      case (err_mode)
        2'd0: m_pos = '0;
        2'd1: m_pos = err_fixed;
        2'd2: begin
          p     = (m_ptr == 0) ? 1 : m_ptr;
          m_pos = POS_W'(p);
          m_ptr = (p == MAXP) ? 1 : p + 1;
        end
        default: begin
          m_pos = POS_W'(m_ptr);
          m_ptr = (m_ptr + 1) % (MAXP + 1);
        end
      endcase
      exp_q.push_back('{word: word_in, pos: m_pos});
    end else if (m_active) begin
      m_k++;
      if (m_k == 2 * WORD_W + 1) m_cnt++;
    end
  end

  // ---------------- monitor / scoreboard (samples on falling edge) ------------
  logic e_ready, e_strobe, e_done, e_d;
  exp_t e;

  always @(negedge clk) begin
    e_ready  = !m_active || m_k >= FRAME;
    e_strobe = m_active && m_k >= 2 && m_k <= 2 * WORD_W && (m_k % 2 == 0);
    e_done   = m_active && m_k == 2 * WORD_W + 1;
    e_d      = (m_active && m_k <= 2 * WORD_W) ? m_word[(m_k - 1) / 2] : 1'b0;
    check("word_ready", word_ready, e_ready);
    check("busy", busy, !e_ready);
    check("strobe_ser", strobe_ser, e_strobe);
    check("frame_done", frame_done, e_done);
    check("d_ser", d_ser, e_d);
    check("error_pos", error_pos, m_pos);
    check("frame_cnt", frame_cnt, m_cnt);

    // behavioural error injector fed by the serial stream
    if (strobe_ser === 1'b1) begin
      if (rx_n < WORD_W) begin
        rx_word[rx_n]  = d_ser;
        inj_word[rx_n] = d_ser ^ (error_pos == POS_W'(rx_n + 1));
      end
      rx_n++;
    end
    if (frame_done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_frame: got frame_done with empty queue at t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_word", rx_word, e.word);
        check("sb_bits", rx_n, WORD_W);
        check("sb_injected", inj_word, e.word ^ pos_mask(e.pos));
        check("sb_pos", error_pos, e.pos);
        pos_log.push_back(int'(error_pos));
      end
      rx_n = 0; rx_word = '0; inj_word = '0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [WORD_W-1:0] w, input logic [1:0] m, input logic [POS_W-1:0] f);
    int guard = 0;
    word_in = w; err_mode = m; err_fixed = f; word_valid = 1'b1;
    while (word_ready !== 1'b1 && guard < 4 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 4 * FRAME) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: word_ready low for %0d cycles, required high", guard);
    end
    @(negedge clk);
    word_valid = 1'b0;
  endtask

  task automatic drain();
    word_valid = 1'b0;
    repeat (2 * FRAME) @(negedge clk);
  endtask

  int dir_exp[$] = '{0, 1, 2, 3, 4, 5, 6, 7, 1, 2, 3, 4, 5, 6, 7, 5, 2};
  int n_dir;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // mode0 known word
    send(7'b1010011, 2'd0, '0);
    drain();
    check("t1_frame_cnt", frame_cnt, 1);

    // sweep 1..7 for 9 frames, then sweep 0..7 continuing from the pointer
    for (int i = 0; i < 9; i++) send(WORD_W'($urandom), 2'd2, POS_W'($urandom));
    for (int i = 0; i < 5; i++) send(WORD_W'($urandom), 2'd3, POS_W'($urandom));

    // fixed position changed mid-frame: takes effect on the next frame
    send(WORD_W'($urandom), 2'd1, 3'd5);
    repeat (4) @(negedge clk);
    err_fixed = 3'd2;
    err_mode  = 2'd3;
    repeat (3) @(negedge clk);
    err_mode  = 2'd1;
    send(WORD_W'($urandom), 2'd1, 3'd2);
    drain();

    n_dir = dir_exp.size();
    check("dir_log_len", pos_log.size(), n_dir);
    for (int i = 0; i < n_dir && i < pos_log.size(); i++)
      check("dir_pos", pos_log[i], dir_exp[i]);

    // valid held high: back-to-back acceptances at the minimum period
    word_valid = 1'b1;
    for (int c = 0; c < 10 * FRAME; c++) begin
      word_in   = WORD_W'($urandom);
      err_mode  = 2'($urandom);
      err_fixed = POS_W'($urandom);
      @(negedge clk);
    end
    drain();

    // reset at bit 3 of a frame aborts it
    send(WORD_W'($urandom), 2'd1, 3'd4);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", word_ready, 1);
    check("rst_cnt", frame_cnt, 0);
    repeat (FRAME) @(negedge clk);
    check("rst_cnt_after", frame_cnt, 0);

    // randomized traffic, enough frames to wrap the counter
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 3)) begin
        err_mode  = 2'($urandom);
        err_fixed = POS_W'($urandom);
        @(negedge clk);
      end
      send(WORD_W'($urandom), 2'($urandom), POS_W'($urandom));
      repeat ($urandom_range(0, 20)) begin
        word_valid = 1'($urandom);
        word_in    = WORD_W'($urandom);
        err_mode   = 2'($urandom);
        err_fixed  = POS_W'($urandom);
        @(negedge clk);
      end
    end
    drain();
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
